// File: rtl/dafx_pkg.sv
// rtl/dafx_pkg.sv - shared DAFX datapath widths, mixer defaults and mixer state encoding
package dafx_pkg;

    localparam int AUDIO_WIDTH_C          = 24;
    localparam int GAIN_WIDTH_C           = 24;
    localparam int Q_BITS_C               = 11;
    localparam int GAIN_Q_BITS_C          = Q_BITS_C;
    localparam int MIXER_NR_OF_CHANNELS_C = 3;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        SCALE,
        OUT
    } mixer_state_t;

endpackage

// File: rtl/dafx_saturate.sv
// rtl/dafx_saturate.sv - arithmetic right shift (floor) followed by clamp to a narrower signed width
module dafx_saturate #(
    parameter int IN_W  = 56,
    parameter int OUT_W = 24,
    parameter int SHIFT = 11
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout,
    output logic                    clip
);

    logic signed [IN_W-1:0]   shifted;
    logic        [IN_W-OUT_W:0] upper;

    assign shifted = din >>> SHIFT;
    assign upper   = shifted[IN_W-1:OUT_W-1];

    // In range only when every bit above the output sign bit matches it.
    assign clip = ~((&upper) | ~(|upper));

    always_comb begin
        dout = shifted[OUT_W-1:0];
        if (clip) begin
            dout = shifted[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/dafx_channel_mixer.sv
// rtl/dafx_channel_mixer.sv - N-channel gain/mute mixer with one time-shared multiplier
// Optional peak meter output sr_peak when DAFX_MIXER_PEAK_EN is defined.
module dafx_channel_mixer
    import dafx_pkg::*;
#(
    parameter int AUDIO_WIDTH_P    = AUDIO_WIDTH_C,
    parameter int GAIN_WIDTH_P     = GAIN_WIDTH_C,
    parameter int Q_BITS_P         = GAIN_Q_BITS_C,
    parameter int NR_OF_CHANNELS_P = MIXER_NR_OF_CHANNELS_C
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      x_valid,
    output logic                                      x_ready,
    input  logic [NR_OF_CHANNELS_P*AUDIO_WIDTH_P-1:0] x_data,
    input  logic [NR_OF_CHANNELS_P*GAIN_WIDTH_P-1:0]  cr_gain,
    input  logic [NR_OF_CHANNELS_P-1:0]               cr_mute,
    output logic                                      y_valid,
    input  logic                                      y_ready,
    output logic [AUDIO_WIDTH_P-1:0]                  y_data,
    output logic                                      sr_clip,
    input  logic                                      cmd_clear_status
`ifdef DAFX_MIXER_PEAK_EN
    ,
    output logic [AUDIO_WIDTH_P-2:0]                  sr_peak
`endif
);

    localparam int PROD_W = AUDIO_WIDTH_P + GAIN_WIDTH_P;
    localparam int ACC_W  = PROD_W + $clog2(NR_OF_CHANNELS_P) + 1;
    localparam int CNT_W  = (NR_OF_CHANNELS_P > 1) ? $clog2(NR_OF_CHANNELS_P) : 1;
    localparam logic [CNT_W-1:0] LAST_CH = CNT_W'(NR_OF_CHANNELS_P - 1);

    mixer_state_t state, next_state;

    logic signed [AUDIO_WIDTH_P-1:0] samp_q [NR_OF_CHANNELS_P];
    logic signed [GAIN_WIDTH_P-1:0]  gain_q [NR_OF_CHANNELS_P];
    logic        [NR_OF_CHANNELS_P-1:0] mute_q;
    logic        [CNT_W-1:0]         cnt;
    logic signed [ACC_W-1:0]         acc;
    logic signed [PROD_W-1:0]        samp_ext, gain_ext, prod;
    logic signed [AUDIO_WIDTH_P-1:0] sat_y;
    logic                            sat_clip;
    logic                            accept;

    assign x_ready = rst_n && (state == IDLE);
    assign accept  = x_valid && x_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (x_valid)         next_state = MAC;
            MAC:     if (cnt == LAST_CH)  next_state = SCALE;
            SCALE:                        next_state = OUT;
            OUT:     if (y_ready)         next_state = IDLE;
            default:                      next_state = IDLE;
        endcase
    end

    assign samp_ext = PROD_W'(samp_q[cnt]);
    assign gain_ext = PROD_W'(gain_q[cnt]);
    assign prod     = samp_ext * gain_ext;

    dafx_saturate #(
        .IN_W  (ACC_W),
        .OUT_W (AUDIO_WIDTH_P),
        .SHIFT (Q_BITS_P)
    ) u_saturate (
        .din  (acc),
        .dout (sat_y),
        .clip (sat_clip)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NR_OF_CHANNELS_P; i++) begin
                samp_q[i] <= '0;
                gain_q[i] <= '0;
            end
            mute_q  <= '0;
            cnt     <= '0;
            acc     <= '0;
            y_valid <= 1'b0;
            y_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        // Snapshot controls so host writes mid-frame cannot corrupt the mix.
                        for (int i = 0; i < NR_OF_CHANNELS_P; i++) begin
                            samp_q[i] <= x_data[i*AUDIO_WIDTH_P +: AUDIO_WIDTH_P];
                            gain_q[i] <= cr_gain[i*GAIN_WIDTH_P +: GAIN_WIDTH_P];
                        end
                        mute_q <= cr_mute;
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                MAC: begin
                    if (!mute_q[cnt]) begin
                        acc <= acc + ACC_W'(prod);
                    end
                    cnt <= cnt + CNT_W'(1);
                end
                SCALE: begin
                    y_data  <= sat_y;
                    y_valid <= 1'b1;
                end
                OUT: begin
                    if (y_ready) begin
                        y_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr_clip <= 1'b0;
        end else if (state == SCALE && sat_clip) begin
            sr_clip <= 1'b1;
        end else if (cmd_clear_status) begin
            sr_clip <= 1'b0;
        end
    end

`ifdef DAFX_MIXER_PEAK_EN
    logic [AUDIO_WIDTH_P-2:0] abs_y;

    // |min negative| does not fit, so it reads as full scale.
    always_comb begin
        abs_y = y_data[AUDIO_WIDTH_P-2:0];
        if (y_data[AUDIO_WIDTH_P-1]) begin
            if (y_data[AUDIO_WIDTH_P-2:0] == '0) begin
                abs_y = '1;
            end else begin
                abs_y = ~y_data[AUDIO_WIDTH_P-2:0] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr_peak <= '0;
        end else if (y_valid && y_ready) begin
            if (abs_y > sr_peak) begin
                sr_peak <= abs_y;
            end
        end else if (cmd_clear_status) begin
            sr_peak <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_dafx_channel_mixer.sv
// tb/tb_dafx_channel_mixer.sv - directed scoreboard bench for dafx_channel_mixer
module tb_dafx_channel_mixer;

    localparam int NR = 3;
    localparam int AW = 24;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              x_valid = 1'b0;
    logic              x_ready;
    logic [NR*AW-1:0]  x_data = '0;
    logic [NR*AW-1:0]  cr_gain = '0;
    logic [NR-1:0]     cr_mute = '0;
    logic              y_valid;
    logic              y_ready = 1'b0;
    logic [AW-1:0]     y_data;
    logic              sr_clip;
    logic              cmd_clear_status = 1'b0;
`ifdef DAFX_MIXER_PEAK_EN
    logic [AW-2:0]     sr_peak;
`endif

    int checks = 0;
    int errors = 0;
    int hs_count = 0;
    logic [AW-1:0] sb [$];

    always #5 clk = ~clk;

    dafx_channel_mixer dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .x_valid          (x_valid),
        .x_ready          (x_ready),
        .x_data           (x_data),
        .cr_gain          (cr_gain),
        .cr_mute          (cr_mute),
        .y_valid          (y_valid),
        .y_ready          (y_ready),
        .y_data           (y_data),
        .sr_clip          (sr_clip),
        .cmd_clear_status (cmd_clear_status)
`ifdef DAFX_MIXER_PEAK_EN
        ,
        .sr_peak          (sr_peak)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Pop one expected sample per output handshake.
    always @(negedge clk) begin
        if (rst_n && y_valid && y_ready) begin
            logic [AW-1:0] exp;
            hs_count++;
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp = sb.pop_front();
                chk("y_data", 32'(y_data), 32'(exp));
            end
        end
    end

    task automatic send(input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [AW-1:0] c,
                        input logic [AW-1:0] ga, input logic [AW-1:0] gb, input logic [AW-1:0] gc,
                        input logic [NR-1:0] m, input bit push, input logic [AW-1:0] exp);
        bit ok = 1'b0;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            ok = x_ready;
        end
        chk("x_ready_wait", 32'(ok), 32'd1);
        x_data  = {c, b, a};
        cr_gain = {gc, gb, ga};
        cr_mute = m;
        x_valid = 1'b1;
        if (push) sb.push_back(exp);
        @(posedge clk);
        #1 x_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 200 && (sb.size() != 0 || !x_ready); k++) @(negedge clk);
        chk({tag, "_sb_drained"}, 32'(sb.size()), 32'd0);
        chk({tag, "_idle"}, 32'(x_ready), 32'd1);
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        cmd_clear_status = 1'b1;
        @(posedge clk);
        #1 cmd_clear_status = 1'b0;
        @(negedge clk);
    endtask

    localparam logic [AW-1:0] UNITY = 24'd2048;

    initial begin
        int lat;
        bit stable;
        bit quiet;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_x_ready", 32'(x_ready), 32'd0);
        chk("rst_y_valid", 32'(y_valid), 32'd0);
        chk("rst_y_data", 32'(y_data), 32'd0);
        chk("rst_sr_clip", 32'(sr_clip), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        y_ready = 1'b1;

        // Basic mix and latency
        send(24'd1000, 24'd2000, -24'sd500, UNITY, UNITY, UNITY, 3'b000, 1'b1, 24'd2500);
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (y_valid) begin
                lat = k - 1;
                break;
            end
        end
        chk("latency", 32'(lat), 32'(NR + 1));
        drain("t1");
        chk("t1_clip", 32'(sr_clip), 32'd0);

        // Positive saturation and clear
        send(24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, UNITY, UNITY, UNITY, 3'b000, 1'b1, 24'h7FFFFF);
        drain("t2");
        chk("t2_clip_set", 32'(sr_clip), 32'd1);
`ifdef DAFX_MIXER_PEAK_EN
        chk("t2_peak", 32'(sr_peak), 32'h7FFFFF);
`endif
        pulse_clear();
        chk("t2_clip_cleared", 32'(sr_clip), 32'd0);
`ifdef DAFX_MIXER_PEAK_EN
        chk("t2_peak_cleared", 32'(sr_peak), 32'd0);
`endif

        // Negative saturation, then floor rounding of -1.5
        send(24'h800000, 24'h800000, 24'h800000, UNITY, UNITY, UNITY, 3'b000, 1'b1, 24'h800000);
        drain("t3a");
        chk("t3_clip_set", 32'(sr_clip), 32'd1);
        pulse_clear();
        send(-24'sd3, 24'd0, 24'd0, 24'd1024, UNITY, UNITY, 3'b110, 1'b1, -24'sd2);
        drain("t3b");
        chk("t3_clip_clear", 32'(sr_clip), 32'd0);
`ifdef DAFX_MIXER_PEAK_EN
        chk("t3_peak", 32'(sr_peak), 32'd2);
`endif

        // Mute, and gain change while the frame is in flight
        send(24'd100, 24'd5000, 24'd200, UNITY, UNITY, UNITY, 3'b010, 1'b1, 24'd300);
        cr_gain = '0;
        drain("t4");

        // Backpressure
        y_ready = 1'b0;
        send(24'd10, 24'd20, 24'd30, UNITY, UNITY, UNITY, 3'b000, 1'b1, 24'd60);
        for (int k = 0; k < 20 && !y_valid; k++) @(negedge clk);
        chk("t5_y_valid_up", 32'(y_valid), 32'd1);
        stable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (y_valid !== 1'b1 || y_data !== 24'd60 || x_ready !== 1'b0) stable = 1'b0;
        end
        chk("t5_hold_stable", 32'(stable), 32'd1);
        @(posedge clk);
        #1 y_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t5_x_ready_after_hs", 32'(x_ready), 32'd1);
        chk("t5_y_valid_after_hs", 32'(y_valid), 32'd0);

        // Reset during MAC discards the frame
        send(24'd5, 24'd5, 24'd5, UNITY, UNITY, UNITY, 3'b000, 1'b0, 24'd0);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        quiet = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (y_valid !== 1'b0) quiet = 1'b0;
        end
        chk("t6_no_y_valid", 32'(quiet), 32'd1);
        send(24'd1, 24'd1, 24'd1, UNITY, UNITY, UNITY, 3'b000, 1'b1, 24'd3);
        drain("t6");

        chk("handshake_count", 32'(hs_count), 32'd7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
